// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared constants and types for the 7-segment scan driver.
//   NUM_DIGITS : number of multiplexed digits
//   seg_t      : 8-bit active-low segment pattern, bit7 = dp
//   SSEG_BLANK : all segments off
//   AN_OFF     : all digit enables off (active-low)
//   an_select  : active-low one-hot enable for a digit index
// -----------------------------------------------------------------------------
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [7:0] seg_t;

  localparam seg_t       SSEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/mux_slot_timer.sv
// -----------------------------------------------------------------------------
// mux_slot_timer
// Slot timing for the digit scan: a cycle counter that wraps every
// REFRESH_DIV cycles and a 2-bit digit index that advances on each wrap.
//   clk, rst_n : clock, asynchronous active-low reset
//   idx        : digit currently being scanned (0..3)
//   drive      : 1 in the DRIVE phase, 0 in the BLANK dead-time at slot start
//   capture    : 1 on the final cycle of digit 3 (frame boundary)
// Parameters: REFRESH_DIV (>= 2) cycles per slot, DEAD_CYCLES (0..REFRESH_DIV-1)
// blanked cycles at the start of each slot.
// -----------------------------------------------------------------------------
module mux_slot_timer #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] idx,
  output logic       drive,
  output logic       capture
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             slot_last;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_last = (cnt_q == CNT_LAST);
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;  // 3 wraps to 0 through the 2-bit width
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // With no dead-time the comparison would be trivially true, so skip it.
  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign drive = 1'b1;
    end else begin : g_dead
      assign drive = (cnt_q >= CNT_W'(DEAD_CYCLES));
    end
  endgenerate

  assign idx     = idx_q;
  assign capture = slot_last && (idx_q == 2'd3);

endmodule

// File: rtl/sseg_mux_scan.sv
// -----------------------------------------------------------------------------
// sseg_mux_scan
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// A coherent frame of the four digit patterns is latched once per full scan,
// then each digit is driven in turn on a shared segment bus, with blanking
// dead-time at the start of every slot to suppress ghosting.
//   clk, rst_n      : clock, asynchronous active-low reset
//   hex0..hex3      : per-digit active-low patterns (hex0 rightmost, bit7 = dp)
//   bright[3:0]     : PWM brightness, only with SSEG_MUX_DIM_EN defined
//   an[3:0]         : active-low digit enables, an[i] selects digit i
//   sseg[7:0]       : active-low shared segment bus
//   frame_tick      : one-cycle pulse in the cycle after a frame is latched
// Optional build macro: SSEG_MUX_DIM_EN adds the bright input and a 16-step
// PWM dimmer that gates the DRIVE phase.
// Outputs are registered: an/sseg in cycle k+1 reflect the scan state of
// cycle k.
// -----------------------------------------------------------------------------
module sseg_mux_scan
  import sseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hex0,
  input  logic [7:0] hex1,
  input  logic [7:0] hex2,
  input  logic [7:0] hex3,
`ifdef SSEG_MUX_DIM_EN
  input  logic [3:0] bright,
`endif
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  logic [1:0] idx;
  logic       drive;
  logic       capture;

  mux_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (idx),
    .drive   (drive),
    .capture (capture)
  );

  seg_t       f_q [NUM_DIGITS];
  seg_t       f_d [NUM_DIGITS];
  logic       valid_q, valid_d;
  logic [3:0] an_q, an_d;
  seg_t       sseg_q, sseg_d;
  logic       frame_tick_q, frame_tick_d;
  logic       lit;

`ifdef SSEG_MUX_DIM_EN
  logic [3:0] pwm_q, pwm_d;
`endif

  always_comb begin
    f_d          = f_q;
    valid_d      = valid_q;
    frame_tick_d = capture;
    an_d         = AN_OFF;
    sseg_d       = SSEG_BLANK;

    if (capture) begin
      f_d[0]  = hex0;
      f_d[1]  = hex1;
      f_d[2]  = hex2;
      f_d[3]  = hex3;
      valid_d = 1'b1;
    end

    // Until the first frame has been latched the display stays fully dark
    // (no digit enabled), so a scan restart always begins with a blank frame.
    lit = drive && valid_q;

`ifdef SSEG_MUX_DIM_EN
    // pwm free-runs through DRIVE cycles only; bright is used unlatched.
    pwm_d = drive ? pwm_q + 4'd1 : pwm_q;
    lit   = lit && (pwm_q < bright);
`endif

    if (lit) begin
      an_d   = an_select(idx);
      sseg_d = f_q[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the frame registers are an addressable array but are reset like
      // any other flop, because the first displayed frame must be blank.
      for (int i = 0; i < NUM_DIGITS; i++) f_q[i] <= SSEG_BLANK;
      valid_q      <= 1'b0;
      an_q         <= AN_OFF;
      sseg_q       <= SSEG_BLANK;
      frame_tick_q <= 1'b0;
`ifdef SSEG_MUX_DIM_EN
      pwm_q        <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) f_q[i] <= f_d[i];
      valid_q      <= valid_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
`ifdef SSEG_MUX_DIM_EN
      pwm_q        <= pwm_d;
`endif
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_mux_scan.sv
// -----------------------------------------------------------------------------
// tb_sseg_mux_scan
// Two scan drivers (REFRESH_DIV=8 with DEAD_CYCLES=2 and 0) share clock,
// reset and digit inputs. Each cycle the expected registered outputs are
// pushed to a scoreboard and compared one cycle later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sseg_mux_scan;

  localparam int RD     = 8;
  localparam int DEAD_A = 2;
  localparam int DEAD_B = 0;
  localparam int FRAME  = 4 * RD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] hx [4];
  logic [3:0] an_a, an_b;
  logic [7:0] sseg_a, sseg_b;
  logic       tick_a, tick_b;
`ifdef SSEG_MUX_DIM_EN
  logic [3:0] bright = 4'hF;
`endif

  always #5 clk = ~clk;

  sseg_mux_scan #(.REFRESH_DIV(RD), .DEAD_CYCLES(DEAD_A)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .hex0       (hx[0]),
    .hex1       (hx[1]),
    .hex2       (hx[2]),
    .hex3       (hx[3]),
`ifdef SSEG_MUX_DIM_EN
    .bright     (bright),
`endif
    .an         (an_a),
    .sseg       (sseg_a),
    .frame_tick (tick_a)
  );

  sseg_mux_scan #(.REFRESH_DIV(RD), .DEAD_CYCLES(DEAD_B)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .hex0       (hx[0]),
    .hex1       (hx[1]),
    .hex2       (hx[2]),
    .hex3       (hx[3]),
`ifdef SSEG_MUX_DIM_EN
    .bright     (bright),
`endif
    .an         (an_b),
    .sseg       (sseg_b),
    .frame_tick (tick_b)
  );

  typedef struct {
    logic [3:0] an_a;
    logic [7:0] sseg_a;
    logic [3:0] an_b;
    logic [7:0] sseg_b;
    logic       tick;
  } exp_t;

  exp_t       sb [$];
  int         passed = 0;
  int         total  = 0;
  int         k      = 0;   // cycles since reset release (current cycle)
  int         last_tick = -1;
  logic [7:0] mf [4];       // frame the bench expects to be displayed

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {an, sseg} for the scan state of cycle kk.
  function automatic logic [11:0] expect_out(input int kk, input int dead);
    int         cnt;
    int         idx;
    logic [3:0] sel;
    cnt = kk % RD;
    idx = (kk / RD) % 4;
    if (kk < FRAME || cnt < dead) return {4'hF, 8'hFF};
    sel = 4'b0001 << idx;
    return {~sel, mf[idx]};
  endfunction

  // Called at the negedge of cycle k: compare last cycle's expectation,
  // push this cycle's, then advance to the next negedge.
  task automatic step();
    exp_t       e;
    logic [11:0] oa, ob;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("an_a",   an_a,   e.an_a);
      check("sseg_a", sseg_a, e.sseg_a);
      check("an_b",   an_b,   e.an_b);
      check("sseg_b", sseg_b, e.sseg_b);
      check("tick_a", tick_a, e.tick);
      check("tick_b", tick_b, e.tick);
      check("onehot_a", 32'($countones(~an_a) <= 1), 1);
      check("onehot_b", 32'($countones(~an_b) <= 1), 1);
      if (tick_a === 1'b1) begin
        check("tick_align", k % FRAME, 0);
        if (last_tick >= 0) check("tick_spacing", k - last_tick, FRAME);
        last_tick = k;
      end
    end
    oa = expect_out(k, DEAD_A);
    ob = expect_out(k, DEAD_B);
    e.an_a   = oa[11:8];
    e.sseg_a = oa[7:0];
    e.an_b   = ob[11:8];
    e.sseg_b = ob[7:0];
    e.tick   = ((k % FRAME) == FRAME - 1);
    sb.push_back(e);
    if ((k % FRAME) == FRAME - 1) for (int i = 0; i < 4; i++) mf[i] = hx[i];
    k++;
    @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    k = 0;
    last_tick = -1;
    sb.delete();
    for (int i = 0; i < 4; i++) mf[i] = 8'hFF;
  endtask

  initial begin
    hx[0] = 8'hC0;
    hx[1] = 8'hF9;
    hx[2] = 8'hA4;
    hx[3] = 8'hB0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_an_a",   an_a,   4'hF);
    check("rst_sseg_a", sseg_a, 8'hFF);
    check("rst_tick_a", tick_a, 1'b0);
    check("rst_an_b",   an_b,   4'hF);

    // Blank first frame, then frame 1 with the initial patterns.
    release_reset();
    while (k < 52) step();

    // Mid-frame change of digit 2: frame 1 keeps A4, frame 2 shows 99.
    hx[2] = 8'h99;
    while (k < 116) step();

    // Cycle 116 shows the state of cycle 115: digit 2 mid-DRIVE.
    check("pre_reset_an_a",   an_a,   4'b1011);
    check("pre_reset_sseg_a", sseg_a, 8'h99);
    check("pre_reset_an_b",   an_b,   4'b1011);

    #1 rst_n = 1'b0;
    #1;
    check("async_rst_an_a",   an_a,   4'hF);
    check("async_rst_sseg_a", sseg_a, 8'hFF);
    check("async_rst_an_b",   an_b,   4'hF);
    check("async_rst_sseg_b", sseg_b, 8'hFF);
    check("async_rst_tick",   tick_a, 1'b0);
    repeat (2) @(negedge clk);

    // Scan restarts at idx 0 with a blank frame; frame 1 now shows 99 on digit 2.
    release_reset();
    while (k < 80) step();
    check("tick_seen", 32'(last_tick == 2 * FRAME), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
